// File: rtl/jpeg_frame_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_pkg
// Description : Shared constants, state encoding and row-count helper for the
//               JPEG frame sequencer and its stage controllers.
// Revision    : 1.0 - initial release
// ============================================================================
package jpeg_pkg;

    localparam int ADDR_W    = 15;
    localparam int BLK_ROWS  = 8;
    localparam int NUM_BLK_W = 12;
    localparam int PIPE_LAT  = 48;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // 4095 blocks * 8 rows = 32760, which still fits the 15-bit address space
    function automatic logic [ADDR_W-1:0] rows_of(input logic [NUM_BLK_W-1:0] blocks);
        return ADDR_W'(blocks) * ADDR_W'(BLK_ROWS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/jpeg_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_frame_sequencer_if
// Description : Control and frame-buffer/pipeline signals of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface jpeg_frame_sequencer_if #(
    parameter int ADDR_W = jpeg_pkg::ADDR_W
);
    import jpeg_pkg::*;

    logic                 start;
    logic [NUM_BLK_W-1:0] num_blocks;
    logic                 stall;
    logic                 abort;
    logic                 busy;
    logic                 done;
    logic                 rd_en;
    logic [ADDR_W-1:0]    rd_addr;
    logic                 pipe_en;
    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;

    modport master (
        output start, num_blocks, stall, abort,
        input  busy, done, rd_en, rd_addr, pipe_en, wr_en, wr_addr
    );

    modport slave (
        input  start, num_blocks, stall, abort,
        output busy, done, rd_en, rd_addr, pipe_en, wr_en, wr_addr
    );

endinterface
`default_nettype wire

// File: rtl/jpeg_valid_delay.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_valid_delay
// Description : Enable-gated 1-bit shift line tracking valid rows through a
//               fixed-latency pipeline; async active-low reset, sync clear.
// Revision    : 1.0 - initial release
// ============================================================================
module jpeg_valid_delay #(
    parameter int DEPTH = jpeg_pkg::PIPE_LAT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] r_line;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_line <= '0;
        end else if (clr) begin
            r_line <= '0;
        end else if (en) begin
            r_line <= {r_line[DEPTH-2:0], din};
        end
    end

    assign dout = r_line[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/jpeg_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_frame_sequencer
// Description : Frame-level controller: issues row reads, gates the pipeline
//               clock-enable, tracks in-flight rows and issues row writes.
// Revision    : 1.0 - initial release
// ============================================================================
module jpeg_frame_sequencer #(
    parameter int ADDR_W   = jpeg_pkg::ADDR_W,
    parameter int PIPE_LAT = jpeg_pkg::PIPE_LAT
) (
    input  logic                 clk,
    input  logic                 reset,
    jpeg_frame_sequencer_if.slave bus
);
    import jpeg_pkg::*;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_total;
    logic [ADDR_W-1:0] r_rd_cnt;
    logic [ADDR_W-1:0] r_wr_cnt;
    logic [ADDR_W-1:0] w_last_addr;
    logic              w_active;
    logic              w_start_ok;
    logic              w_abort;
    logic              w_pipe_en;
    logic              w_rd_en;
    logic              w_wr_en;
    logic              w_last_rd;
    logic              w_last_wr;
    logic              w_dly_out;
    logic              w_dly_clr;

    assign w_active    = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_start_ok  = (r_state == ST_IDLE) && bus.start && (bus.num_blocks != '0);
    assign w_abort     = (r_state != ST_IDLE) && bus.abort;
    assign w_last_addr = r_total - ADDR_W'(1);
    assign w_dly_clr   = w_start_ok || w_abort;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pipe_en    = 1'b0;
        w_rd_en      = 1'b0;
        w_wr_en      = 1'b0;
        w_last_rd    = 1'b0;
        w_last_wr    = 1'b0;

        // abort outranks stall; either one freezes the pipeline this cycle
        if (w_active && !bus.stall && !bus.abort) begin
            w_pipe_en = 1'b1;
        end
        w_rd_en   = (r_state == ST_RUN) && w_pipe_en;
        w_wr_en   = w_dly_out && w_pipe_en;
        w_last_rd = w_rd_en && (r_rd_cnt == w_last_addr);
        w_last_wr = w_wr_en && (r_wr_cnt == w_last_addr);

        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (w_abort)        w_state_next = ST_IDLE;
                else if (w_last_rd) w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_abort)        w_state_next = ST_IDLE;
                else if (w_last_wr) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Counters stop at total-1 so the address outputs never wrap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_total  <= '0;
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else if (w_start_ok) begin
            r_total  <= ADDR_W'(rows_of(bus.num_blocks));
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else if (w_abort) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (w_rd_en && !w_last_rd) r_rd_cnt <= r_rd_cnt + ADDR_W'(1);
            if (w_wr_en && !w_last_wr) r_wr_cnt <= r_wr_cnt + ADDR_W'(1);
        end
    end

    jpeg_valid_delay #(
        .DEPTH (PIPE_LAT)
    ) u_valid_delay (
        .clk   (clk),
        .reset (reset),
        .clr   (w_dly_clr),
        .en    (w_pipe_en),
        .din   (w_rd_en),
        .dout  (w_dly_out)
    );

    assign bus.busy    = w_active;
    assign bus.done    = (r_state == ST_DONE);
    assign bus.rd_en   = w_rd_en;
    assign bus.rd_addr = r_rd_cnt;
    assign bus.pipe_en = w_pipe_en;
    assign bus.wr_en   = w_wr_en;
    assign bus.wr_addr = r_wr_cnt;

endmodule
`default_nettype wire
